// File: rtl/ps2_scan_code_receiver_if.sv
// PS/2 receiver bundle: raw keyboard lines in, decoded Set-2 scan code and status pulses out.
// The master drives the lines and consumes codes; the slave is the receiver.
interface ps2_scan_code_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_error;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  scan_code_valid,
    input  is_break,
    input  is_extended,
    input  frame_error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output scan_code_valid,
    output is_break,
    output is_extended,
    output frame_error
  );
endinterface

// File: rtl/ps2_scan_code_receiver.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame deserializer, E0/F0 prefix folding.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_scan_code_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  ps2_scan_code_receiver_if.slave  ps2_bus
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

`ifdef PS2_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction
`endif

  logic              r_clk_meta;
  logic              r_clk_sync;
  logic              r_data_meta;
  logic              r_data_sync;
  logic              r_clk_filt;
  logic              r_clk_filt_d;
  logic [FILT_W-1:0] r_filt_cnt;

  logic [1:0]        r_state;
  logic [7:0]        r_shift;
  logic [3:0]        r_bit_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
`ifdef PS2_PARITY_CHECK_EN
  logic              r_parity_bit;
  logic              w_parity_nxt;
`endif

  logic              r_break_pend;
  logic              r_ext_pend;
  logic [7:0]        r_scan_code;
  logic              r_scan_code_valid;
  logic              r_is_break;
  logic              r_is_extended;
  logic              r_frame_error;

  logic              w_bit_event;
  logic              w_bit;
  logic              w_timeout;
  logic              w_parity_ok;
  logic [1:0]        w_state_nxt;
  logic [7:0]        w_shift_nxt;
  logic [3:0]        w_bit_cnt_nxt;
  logic              w_frame_done;
  logic              w_eval_error;
  logic              w_take_code;
  logic              w_set_break;
  logic              w_set_ext;
  logic              w_drop_frame;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_bus.ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= ps2_bus.ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_sync;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
      end
    end
  end

  assign w_bit_event  = r_clk_filt_d & ~r_clk_filt;
  assign w_bit        = r_data_sync;
  assign w_timeout    = (r_state != S_IDLE) && (r_tmo_cnt == TMO_LIMIT) && !w_bit_event;

`ifdef PS2_PARITY_CHECK_EN
  assign w_parity_ok = odd_parity_ok(r_shift, r_parity_bit);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Frame FSM next-state and deserializer datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frame_done  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_parity_nxt  = r_parity_bit;
`endif
    if (w_bit_event) begin
      case (r_state)
        S_IDLE: begin
          if (!w_bit) begin
            w_state_nxt   = S_DATA;
            w_shift_nxt   = 8'h00;
            w_bit_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end
        S_DATA: begin
          w_shift_nxt   = {w_bit, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          w_parity_nxt = w_bit;
`endif
          w_state_nxt  = S_STOP;
        end
        S_STOP: begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Completed-frame classification: stop error beats parity error beats prefix/code decode
  always_comb begin
    w_eval_error = 1'b0;
    w_take_code  = 1'b0;
    w_set_break  = 1'b0;
    w_set_ext    = 1'b0;
    if (!w_frame_done) begin
      w_eval_error = 1'b0;
    end else if (!w_bit) begin
      w_eval_error = 1'b1;
    end else if (!w_parity_ok) begin
      w_eval_error = 1'b1;
    end else if (r_shift == CODE_BREAK) begin
      w_set_break  = 1'b1;
    end else if (r_shift == CODE_EXT) begin
      w_set_ext    = 1'b1;
    end else begin
      w_take_code  = 1'b1;
    end
  end

  assign w_drop_frame = w_eval_error | w_timeout;

  // FSM and frame registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 4'd0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity_bit <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
`ifdef PS2_PARITY_CHECK_EN
      r_parity_bit <= w_parity_nxt;
`endif
    end
  end

  // Inter-edge watchdog: cleared by every bit event and held at zero while idle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_bit_event || (r_state == S_IDLE) || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Output registers and prefix flags; any dropped frame forgets pending prefixes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan_code       <= 8'h00;
      r_scan_code_valid <= 1'b0;
      r_is_break        <= 1'b0;
      r_is_extended     <= 1'b0;
      r_frame_error     <= 1'b0;
      r_break_pend      <= 1'b0;
      r_ext_pend        <= 1'b0;
    end else begin
      r_scan_code_valid <= w_take_code;
      r_frame_error     <= w_drop_frame;
      if (w_take_code) begin
        r_scan_code   <= r_shift;
        r_is_break    <= r_break_pend;
        r_is_extended <= r_ext_pend;
        r_break_pend  <= 1'b0;
        r_ext_pend    <= 1'b0;
      end else if (w_drop_frame) begin
        r_break_pend  <= 1'b0;
        r_ext_pend    <= 1'b0;
      end else begin
        if (w_set_break) begin
          r_break_pend <= 1'b1;
        end
        if (w_set_ext) begin
          r_ext_pend <= 1'b1;
        end
      end
    end
  end

  assign ps2_bus.scan_code       = r_scan_code;
  assign ps2_bus.scan_code_valid = r_scan_code_valid;
  assign ps2_bus.is_break        = r_is_break;
  assign ps2_bus.is_extended     = r_is_extended;
  assign ps2_bus.frame_error     = r_frame_error;

endmodule
